// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the fetch controller and its buffer.
// Build option FETCH_SKID_EN selects a 2-entry skid buffer (default 1 entry).
package fetch_pkg;

    localparam int L_DEF = 16;

`ifdef FETCH_SKID_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    // One buffered fetch: the word and the address it came from.
    typedef struct packed {
        logic [L_DEF-1:0] instr;
        logic [L_DEF-1:0] pc;
    } entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: tiny in-order FIFO (1 or 2 entries) between fetch and decode.
// Head is always slot 0. Slots are never cleared on pop or flush, so the head
// output keeps showing the last word once the buffer runs empty.
// Depth comes from fetch_pkg::BUF_DEPTH (set by FETCH_SKID_EN); the caller
// must not push into a full buffer.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int W = 2 * L_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [1:0][W-1:0] mem;
    logic [1:0]        cnt;
    logic              wr_hi;

    // A push lands in slot 1 only if slot 0 is still occupied after the pop.
    always_comb begin
        wr_hi = (cnt == 2'd2) || ((cnt == 2'd1) && !pop);
    end

    // Storage and occupancy; flush drops everything, including a same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
            cnt <= 2'd0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            if (pop && (cnt == 2'd2) && (BUF_DEPTH > 1))
                mem[0] <= mem[1];
            if (push) begin
                if (wr_hi)
                    mem[1] <= din;
                else
                    mem[0] <= din;
            end
        end
    end

    assign head  = mem[0];
    assign count = cnt;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, reads the combinational instruction memory and
// hands {instr, pc} pairs to decode over valid/ready.
// Build option FETCH_SKID_EN: 2-entry skid buffer, fetch depends only on the
// buffer level (no instr_ready -> pc path). Without it: 1-entry buffer with a
// pass-through ready so a full buffer can still fetch while it drains.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int             L        = L_DEF,
    parameter logic [L-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         halt_req,
    input  logic         redirect_valid,
    input  logic [L-1:0] redirect_pc,
    output logic [L-1:0] imem_addr,
    input  logic [L-1:0] imem_data,
    output logic         instr_valid,
    output logic [L-1:0] instr,
    output logic [L-1:0] instr_pc,
    input  logic         instr_ready,
    output logic         halted,
    output logic         busy
);

    state_t         state_q, state_d;
    logic [L-1:0]   pc_q;
    logic [1:0]     count;
    logic [2*L-1:0] head;
    logic           pop, push, fetch_en, drain_empty;

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && instr_ready;

`ifdef FETCH_SKID_EN
    assign fetch_en = (count < 2'd2);
`else
    assign fetch_en = (count == 2'd0) || instr_ready;
`endif

    // Buffer is empty at the end of this cycle: flushed, or last word popped.
    assign drain_empty = redirect_valid || (count == 2'd0) || ((count == 2'd1) && pop);

    // Next state and fetch decision; redirect suppresses the push but never the FSM.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE, HALT: if (start) state_d = RUN;
            RUN: begin
                if (halt_req)
                    state_d = DRAIN;
                else if (fetch_en && !redirect_valid)
                    push = 1'b1;
            end
            DRAIN: if (drain_empty) state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // PC: redirect wins, otherwise advance on each fetch (wraps naturally).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 pc_q <= RESET_PC;
        else if (redirect_valid) pc_q <= redirect_pc;
        else if (push)           pc_q <= pc_q + {{(L-1){1'b0}}, 1'b1};
    end

    fetch_buffer #(.W(2 * L)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({imem_data, pc_q}),
        .head  (head),
        .count (count)
    );

    assign imem_addr = pc_q;
    assign instr     = head[2*L-1:L];
    assign instr_pc  = head[L-1:0];
    assign halted    = (state_q == HALT);
    assign busy      = (state_q == RUN) || (state_q == DRAIN);

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios plus a random phase, all compared
// against a queue-based reference model of the fetch/decode handoff.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst, start, halt_req, rv, rdy;
    logic [15:0] rpc, imem_addr, imem_data, instr, instr_pc;
    logic        instr_valid, halted, busy;

    int nerr = 0;
    int nchk = 0;

`ifdef FETCH_SKID_EN
    localparam int          CAP      = 2;
    localparam logic [15:0] STALL_PC = 16'd2;
`else
    localparam int          CAP      = 1;
    localparam logic [15:0] STALL_PC = 16'd1;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    assign imem_data = memf(imem_addr);

    fetch_controller dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .redirect_valid(rv), .redirect_pc(rpc),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(rdy), .halted(halted), .busy(busy)
    );

    // Reference model: a queue of outstanding words plus mode and pc.
    logic [15:0] q_i[$];
    logic [15:0] q_p[$];
    logic [15:0] m_pc, m_instr, m_ipc;
    int          mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_i.delete(); q_p.delete();
        m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; mode = M_IDLE;
    endtask

    task automatic model_step();
        bit pop, room, fetch;
        pop  = (q_i.size() > 0) && rdy;
        room = (CAP == 2) ? (q_i.size() < 2) : ((q_i.size() == 0) || rdy);
        fetch = (mode == M_RUN) && !halt_req && room && !rv;
        if (pop) begin
            void'(q_i.pop_front());
            void'(q_p.pop_front());
        end
        if (rv) begin
            q_i.delete(); q_p.delete();
            m_pc = rpc;
        end else if (fetch) begin
            q_i.push_back(memf(m_pc));
            q_p.push_back(m_pc);
            m_pc = m_pc + 16'd1;
        end
        if (q_i.size() > 0) begin
            m_instr = q_i[0];
            m_ipc   = q_p[0];
        end
        case (mode)
            M_IDLE, M_HALT: if (start) mode = M_RUN;
            M_RUN:          if (halt_req) mode = M_DRAIN;
            M_DRAIN:        if (q_i.size() == 0) mode = M_HALT;
            default:        mode = M_IDLE;
        endcase
    endtask

    task automatic check_model();
        chk("valid",  instr_valid, q_i.size() > 0);
        chk("instr",  instr,       m_instr);
        chk("ipc",    instr_pc,    m_ipc);
        chk("addr",   imem_addr,   m_pc);
        chk("halted", halted,      mode == M_HALT);
        chk("busy",   busy,        (mode == M_RUN) || (mode == M_DRAIN));
        if (instr_valid === 1'b1)
            chk("memword", instr, memf(instr_pc));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; rv = 1'b0; rpc = '0; rdy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        rst = 1'b0;
        tick();

        // Start with decode stalled: pc stops once the buffer fills.
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        chk("stall_pc", imem_addr, STALL_PC);
        rdy = 1'b1;
        repeat (8) tick();

        // Redirect while words are buffered.
        rdy = 1'b0;
        repeat (3) tick();
        rv = 1'b1; rpc = 16'h0014; tick(); rv = 1'b0;
        chk("flushed", instr_valid, 1'b0);
        rdy = 1'b1; tick();
        chk("redir_valid", instr_valid, 1'b1);
        chk("redir_pc", instr_pc, 16'h0014);

        // Halt at pc=5, then resume.
        rv = 1'b1; rpc = 16'h0000; tick(); rv = 1'b0;
        for (int i = 0; i < 20 && imem_addr !== 16'd5; i++) tick();
        chk("reach5", imem_addr, 16'd5);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        for (int i = 0; i < 10 && halted !== 1'b1; i++) tick();
        chk("halt_st", halted, 1'b1);
        chk("halt_pc", imem_addr, 16'd5);
        start = 1'b1; tick(); start = 1'b0; tick();
        chk("resume_v",  instr_valid, 1'b1);
        chk("resume_pc", instr_pc, 16'd5);

        // Address wrap.
        rv = 1'b1; rpc = 16'hFFFE; tick(); rv = 1'b0;
        tick(); chk("wrap0", instr_pc, 16'hFFFE);
        tick(); chk("wrap1", instr_pc, 16'hFFFF);
        tick(); chk("wrap2", instr_pc, 16'h0000);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rdy      = ($urandom_range(0, 3) != 0);
            rv       = ($urandom_range(0, 15) == 0);
            rpc      = 16'($urandom);
            start    = !rv && ($urandom_range(0, 7) == 0);
            halt_req = ($urandom_range(0, 19) == 0);
            tick();
        end
        rv = 1'b0; start = 1'b0; halt_req = 1'b0;

        // Reset mid-run with the buffer full.
        start = 1'b1; rdy = 1'b0; tick(); start = 1'b0;
        repeat (3) tick();
        chk("full_v", instr_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_pc",    imem_addr,   16'h0000);
        chk("rst_busy",  busy,        1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1;
        repeat (3) tick();
        chk("idle_busy", busy, 1'b0);
        start = 1'b1; tick(); start = 1'b0; tick();
        chk("post_v",  instr_valid, 1'b1);
        chk("post_pc", instr_pc, 16'h0000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
